saph_fpu_seq: RTL
=================

SAPH_FPU_SEQ -- requirements
Module: saph_fpu_seq

Interface
REQ-001 SHALL have parameter MUL_BITS: default 1; multiplier bits retired per cycle; legal values 1, 2, 4.
REQ-002 SHALL have port clk, input, 1 bit; sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-004 SHALL have port d_trig, input, 1 bit; GPU requests a computation.
REQ-005 SHALL have ports d_lhs and d_rhs, input, 32 bits each; `float` operands in IEEE-754 binary32 layout.
REQ-006 SHALL have port d_mode, input, 2 bits; 00 MUL, 01 MIN, 10 MAX, 11 NEG (result is -lhs).
REQ-007 SHALL have port d_ready, output, 1 bit; block can accept an operation this cycle.
REQ-008 SHALL have port q_trig, output, 1 bit; one-cycle pulse marking q_res valid.
REQ-009 SHALL have port q_res, output, 32 bits; computation result.

Function
REQ-010 SHALL accept an operation in cycle T iff d_trig=1 and d_ready=1; d_trig is ignored while d_ready=0.
REQ-011 SHALL have states IDLE, MUL and NORM; d_ready=1 exactly when the state is IDLE.
REQ-012 SHALL, for an accepted MIN, MAX or NEG, stay in IDLE, register the result, and assert q_trig in cycle T+1.
REQ-013 SHALL, for an accepted MUL, latch the operands and run MUL for 24/MUL_BITS cycles (shift-add on the 24-bit significands with the hidden bit), then NORM for 1 cycle.
REQ-014 SHALL, for a MUL, return to IDLE and assert q_trig in cycle T+2+24/MUL_BITS (T+26 when MUL_BITS=1).
REQ-015 SHALL accept a new operation in the same cycle that q_trig is high, so back-to-back operations have no bubble.
REQ-016 SHALL hold q_res between results; q_trig SHALL be high for exactly one cycle per accepted operation.
REQ-017 SHALL compute MUL as follows:
  - sign = sa xor sb.
  - Any operand with exponent 0 gives signed zero (denormals flushed).
  - exponent = ea+eb-127, computed at 10-bit signed width; +1 and shift right 1 when product bit 47 is set.
  - Mantissa is truncated (round toward zero).
  - Result exponent <= 0 gives signed zero.
REQ-018 SHALL order MIN/MAX by sign-magnitude value, with -0 < +0; on a tie, it returns d_lhs.
REQ-019 SHALL compute NEG by inverting bit 31 of d_lhs only.

Reset
REQ-020 SHALL, while rst_n=0, force: state=IDLE, q_trig=0, q_res=0x00000000, iteration counter=0, d_ready=1.
REQ-021 SHALL, on reset assertion mid-operation, discard the operation: no q_trig is ever issued for it, and the first accepted operation after release behaves normally.

Configuration
REQ-022 SHALL compile IEEE special-value handling in when macro SAPH_FPU_SPECIAL_EN is defined.
REQ-023 SHALL, with SAPH_FPU_SPECIAL_EN defined, apply these rules:
  - MUL with any NaN operand, or with inf*0, gives 0x7FC00000.
  - Otherwise MUL with an inf operand gives signed inf.
  - MUL exponent >= 255 gives signed inf (0x7F800000 with sign).
  - MIN/MAX with one NaN operand returns the other operand; with both NaN it returns 0x7FC00000.
REQ-024 SHALL, with SAPH_FPU_SPECIAL_EN undefined, treat exponent-255 inputs as ordinary numbers and saturate MUL exponent >= 255 to signed max finite (0x7F7FFFFF with sign).
REQ-025 SHALL keep latency and handshake identical with and without SAPH_FPU_SPECIAL_EN.

Verification
REQ-026 MUL: 0x40000000 * 0x40400000 accepted at T, MUL_BITS=1 -> q_trig=1 at T+26, q_res=0x40C00000, d_ready=0 for T+1..T+25.
REQ-027 MUL: 0x3FC00000 * 0x3FC00000 with MUL_BITS=4 -> q_res=0x40100000 at T+8.
REQ-028 MIN: 0x80000000, 0x00000000 -> q_res=0x80000000 at T+1; MAX of the same pair -> 0x00000000 at T+1.
REQ-029 MUL overflow: 0x7F000000 * 0x7F000000 -> 0x7F800000 with SAPH_FPU_SPECIAL_EN, 0x7F7FFFFF without.
REQ-030 Reset: rst_n=0 at T+10 of a MUL -> q_trig stays 0 and d_ready=1; a NEG of 0x3F800000 issued after release -> 0xBF800000 one cycle later.
REQ-031 Back-to-back: d_trig held 1 through a MUL -> mid-operation requests ignored; the next operation is accepted in the q_trig cycle (T+26) and its result pulses at T+27 (MIN) or T+52 (MUL).

Source files
------------

// File: rtl/saph_fpu_seq.sv
// Sequential binary32 unit: shift-add multiply (MUL_BITS bits per cycle) plus single-cycle MIN/MAX/NEG.
// Define SAPH_FPU_SPECIAL_EN to compile in IEEE NaN/inf handling; otherwise exponent 255 is ordinary and overflow saturates.
module saph_fpu_seq #(
    parameter int MUL_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_trig,
    input  logic [31:0] d_lhs,
    input  logic [31:0] d_rhs,
    input  logic [1:0]  d_mode,
    output logic        d_ready,
    output logic        q_trig,
    output logic [31:0] q_res
);

    localparam int         ITERS    = 24 / MUL_BITS;
    localparam logic [4:0] CNT_LAST = 5'(ITERS - 1);
    localparam logic [1:0] MODE_MUL = 2'b00;
    localparam logic [1:0] MODE_MIN = 2'b01;
    localparam logic [1:0] MODE_MAX = 2'b10;
    localparam logic [1:0] MODE_NEG = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t      state_r, state_nx_s;
    logic [4:0]  cnt_r;
    logic [47:0] mcand_r;
    logic [23:0] mplier_r;
    logic [47:0] prod_r;
    logic [31:0] a_r, b_r;
    logic [31:0] q_res_r;
    logic        q_trig_r;
    logic        accept_s;
    logic [47:0] part_s;
    logic [31:0] imm_res_s;
    logic [31:0] norm_res_s;
    logic [9:0]  exp_sum_s;
    logic [9:0]  exp_n_s;
    logic [22:0] mant_s;
    logic        sign_s;

    // Sign-magnitude ordering: a < b, with -0 below +0.
    function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
        logic r;
        if (a[31] != b[31]) begin
            r = a[31];
        end else if (a[31]) begin
            r = (a[30:0] > b[30:0]);
        end else begin
            r = (a[30:0] < b[30:0]);
        end
        return r;
    endfunction

    function automatic logic f_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic f_is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic f_is_zero(input logic [31:0] x);
        return (x[30:23] == 8'h00);
    endfunction

    assign accept_s = d_trig && (state_r == IDLE);
    assign d_ready  = (state_r == IDLE);
    assign q_trig   = q_trig_r;
    assign q_res    = q_res_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && (d_mode == MODE_MUL)) begin
                    state_nx_s = MUL;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            MUL: begin
                if (cnt_r == 5'd0) begin
                    state_nx_s = NORM;
                end else begin
                    state_nx_s = MUL;
                end
            end
            NORM:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Partial product for the multiplier digit retired this cycle.
    always_comb begin
        part_s = 48'd0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier_r[i]) begin
                part_s = part_s + (mcand_r << i);
            end else begin
                part_s = part_s;
            end
        end
    end

    // Single-cycle MIN/MAX/NEG result.
    always_comb begin
        imm_res_s = d_lhs;
        case (d_mode)
            MODE_MIN: imm_res_s = f_lt(d_rhs, d_lhs) ? d_rhs : d_lhs;
            MODE_MAX: imm_res_s = f_lt(d_lhs, d_rhs) ? d_rhs : d_lhs;
            MODE_NEG: imm_res_s = {~d_lhs[31], d_lhs[30:0]};
            default:  imm_res_s = d_lhs;
        endcase
`ifdef SAPH_FPU_SPECIAL_EN
        if ((d_mode == MODE_MIN) || (d_mode == MODE_MAX)) begin
            if (f_is_nan(d_lhs) && f_is_nan(d_rhs)) begin
                imm_res_s = 32'h7FC0_0000;
            end else if (f_is_nan(d_lhs)) begin
                imm_res_s = d_rhs;
            end else if (f_is_nan(d_rhs)) begin
                imm_res_s = d_lhs;
            end else begin
                imm_res_s = imm_res_s;
            end
        end else begin
            imm_res_s = imm_res_s;
        end
`endif
    end

    // Normalise the 48-bit significand product and pack the result.
    always_comb begin
        sign_s    = a_r[31] ^ b_r[31];
        exp_sum_s = {2'b00, a_r[30:23]} + {2'b00, b_r[30:23]} - 10'd127;
        if (prod_r[47]) begin
            exp_n_s = exp_sum_s + 10'd1;
            mant_s  = prod_r[46:24];
        end else begin
            exp_n_s = exp_sum_s;
            mant_s  = prod_r[45:23];
        end
        if (f_is_zero(a_r) || f_is_zero(b_r)) begin
            norm_res_s = {sign_s, 31'd0};
        end else if ($signed(exp_n_s) <= $signed(10'sd0)) begin
            norm_res_s = {sign_s, 31'd0};
        end else if ($signed(exp_n_s) >= $signed(10'sd255)) begin
`ifdef SAPH_FPU_SPECIAL_EN
            norm_res_s = {sign_s, 31'h7F80_0000};
`else
            norm_res_s = {sign_s, 31'h7F7F_FFFF};
`endif
        end else begin
            norm_res_s = {sign_s, exp_n_s[7:0], mant_s};
        end
`ifdef SAPH_FPU_SPECIAL_EN
        // NaN and inf*0 take priority over every finite rule.
        if (f_is_nan(a_r) || f_is_nan(b_r) ||
            (f_is_inf(a_r) && f_is_zero(b_r)) || (f_is_inf(b_r) && f_is_zero(a_r))) begin
            norm_res_s = 32'h7FC0_0000;
        end else if (f_is_inf(a_r) || f_is_inf(b_r)) begin
            norm_res_s = {sign_s, 31'h7F80_0000};
        end else begin
            norm_res_s = norm_res_s;
        end
`endif
    end

    // Operand latch, shift-add datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= 5'd0;
            mcand_r  <= 48'd0;
            mplier_r <= 24'd0;
            prod_r   <= 48'd0;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            q_res_r  <= 32'd0;
            q_trig_r <= 1'b0;
        end else begin
            q_trig_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s && (d_mode == MODE_MUL)) begin
                        a_r      <= d_lhs;
                        b_r      <= d_rhs;
                        mcand_r  <= {24'd0, 1'b1, d_lhs[22:0]};
                        mplier_r <= {1'b1, d_rhs[22:0]};
                        prod_r   <= 48'd0;
                        cnt_r    <= CNT_LAST;
                    end else if (accept_s) begin
                        q_res_r  <= imm_res_s;
                        q_trig_r <= 1'b1;
                    end else begin
                        q_res_r  <= q_res_r;
                    end
                end
                MUL: begin
                    prod_r   <= prod_r + part_s;
                    mcand_r  <= mcand_r << MUL_BITS;
                    mplier_r <= mplier_r >> MUL_BITS;
                    if (cnt_r != 5'd0) begin
                        cnt_r <= cnt_r - 5'd1;
                    end else begin
                        cnt_r <= 5'd0;
                    end
                end
                NORM: begin
                    q_res_r  <= norm_res_s;
                    q_trig_r <= 1'b1;
                end
                default: begin
                    q_res_r  <= q_res_r;
                end
            endcase
        end
    end

endmodule
